// File: rtl/simple_pkg.sv
// Shared constants, instruction layout, ALU opcodes and the default program
// for the simple accumulator CPU.
package simple_pkg;

    localparam int unsigned DW        = 8;
    localparam int unsigned IW        = 16;
    localparam int unsigned ROM_DEPTH = 32;
    localparam int unsigned PCW       = $clog2(ROM_DEPTH);
    localparam int unsigned RF_DEPTH  = 4;
    localparam int unsigned RFAW      = $clog2(RF_DEPTH);

    typedef enum logic [2:0] {
        ALU_PASS_R   = 3'b000,
        ALU_PASS_IMM = 3'b001,
        ALU_ADD      = 3'b010,
        ALU_SUB      = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110,
        ALU_NOT      = 3'b111
    } alu_op_e;

    // Field order fixes the bit positions: [15] rf_we, [14] a_re, [13:11] op,
    // [10:9] addr, [8] reserved, [7:0] imm.
    typedef struct packed {
        logic            rf_we;
        logic            a_re;
        alu_op_e         op;
        logic [RFAW-1:0] addr;
        logic            rsvd;
        logic [DW-1:0]   imm;
    } instr_t;

    typedef logic [IW-1:0]                instr_word_t;
    typedef instr_word_t [ROM_DEPTH-1:0]  rom_t;

    function automatic rom_t default_rom();
        rom_t r;
        r    = '0;
        r[0] = 16'h4805;
        r[1] = 16'h8000;
        r[2] = 16'h4803;
        r[3] = 16'h5000;
        r[4] = 16'h8200;
        return r;
    endfunction

    localparam rom_t DEFAULT_ROM = default_rom();

endpackage

// File: rtl/simple_alu.sv
// Combinational 8-operation ALU; carries and borrows are dropped.
module simple_alu
    import simple_pkg::*;
(
    input  alu_op_e       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result_c
);

    always_comb begin
        result_c = '0;
        unique case (op)
            ALU_PASS_R:   result_c = r;
            ALU_PASS_IMM: result_c = imm;
            ALU_ADD:      result_c = DW'(a + r);
            ALU_SUB:      result_c = DW'(a - r);
            ALU_AND:      result_c = a & r;
            ALU_OR:       result_c = a | r;
            ALU_XOR:      result_c = a ^ r;
            ALU_NOT:      result_c = ~a;
            default:      result_c = '0;
        endcase
    end

endmodule

// File: rtl/simple_top.sv
// Minimal accumulator CPU: ROM fetch into IR while the previous IR executes
// against the accumulator and a 4-entry register file.
module simple_top
    import simple_pkg::*;
#(
    parameter rom_t ROM_INIT = DEFAULT_ROM
) (
    input  logic            clk,
    input  logic            rst,
    output logic [IW-1:0]   instruction_wire,
    output logic            RF_we,
    output logic            A_re,
    output logic [2:0]      ALU_opcode_wire,
    output logic [RFAW-1:0] RF_addr
);

    logic [PCW-1:0] pc_q;
    instr_t         ir_q;
    logic [DW-1:0]  acc_q;
    logic [DW-1:0]  rf_q [0:RF_DEPTH-1];
    logic [DW-1:0]  alu_result;

    // Decode is a direct view of IR, so it only moves on an edge or reset.
    assign instruction_wire = ir_q;
    assign RF_we            = ir_q.rf_we;
    assign A_re             = ir_q.a_re;
    assign ALU_opcode_wire  = ir_q.op;
    assign RF_addr          = ir_q.addr;

    simple_alu u_alu (
        .op       (ir_q.op),
        .a        (acc_q),
        .r        (rf_q[ir_q.addr]),
        .imm      (ir_q.imm),
        .result_c (alu_result)
    );

    // Fetch and execute share the edge; the RF write takes A from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_q + PCW'(1);
            ir_q <= instr_t'(ROM_INIT[pc_q]);
            if (ir_q.a_re) begin
                acc_q <= alu_result;
            end
            if (ir_q.rf_we) begin
                rf_q[ir_q.addr] <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_simple_top.sv
// Scoreboard bench: a behavioural CPU model predicts state after every edge,
// a negedge monitor compares two DUTs (default program and ALU sweep program).
module tb_simple_top;
    import simple_pkg::*;

    typedef struct packed {
        logic [4:0]      pc;
        logic [15:0]     ir;
        logic [7:0]      acc;
        logic [3:0][7:0] rf;
    } mstate_t;

    typedef struct packed {
        mstate_t s0;
        mstate_t s1;
    } exp_t;

    function automatic rom_t alt_rom();
        rom_t r;
        r     = '0;
        r[0]  = 16'h480F;  r[1]  = 16'h8000;  r[2]  = 16'h48F0;  r[3]  = 16'h5000;
        r[4]  = 16'h48F0;  r[5]  = 16'h5800;  r[6]  = 16'h48F0;  r[7]  = 16'h6000;
        r[8]  = 16'h48F0;  r[9]  = 16'h6800;  r[10] = 16'h48F0;  r[11] = 16'h7000;
        r[12] = 16'h48F0;  r[13] = 16'h7800;  r[14] = 16'h4801;  r[15] = 16'h8200;
        r[16] = 16'h48FF;  r[17] = 16'h5200;  r[18] = 16'h4200;  r[19] = 16'hC877;
        r[20] = 16'h4000;
        return r;
    endfunction

    localparam rom_t ALT_ROM = alt_rom();

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] iw0, iw1;
    logic        we0, we1, re0, re1;
    logic [2:0]  op0, op1;
    logic [1:0]  ad0, ad1;

    exp_t    q[$];
    mstate_t m0, m1;
    int      checks = 0;
    int      errors = 0;
    int      edges  = 0;

    always #5 clk = ~clk;

    simple_top dut0 (
        .clk (clk), .rst (rst), .instruction_wire (iw0), .RF_we (we0),
        .A_re (re0), .ALU_opcode_wire (op0), .RF_addr (ad0)
    );

    simple_top #(.ROM_INIT(ALT_ROM)) dut1 (
        .clk (clk), .rst (rst), .instruction_wire (iw1), .RF_we (we1),
        .A_re (re1), .ALU_opcode_wire (op1), .RF_addr (ad1)
    );

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] r, input logic [7:0] imm);
        int unsigned v;
        case (op)
            3'd0: v = r;
            3'd1: v = imm;
            3'd2: v = (a + r) % 256;
            3'd3: v = (256 + a - r) % 256;
            3'd4: v = a & r;
            3'd5: v = a | r;
            3'd6: v = a ^ r;
            default: v = 255 - a;
        endcase
        return v[7:0];
    endfunction

    function automatic mstate_t step(input mstate_t s, input rom_t rom);
        mstate_t     n;
        logic [15:0] ins;
        n   = s;
        ins = s.ir;
        n.ir = rom[s.pc];
        n.pc = 5'((s.pc + 1) % 32);
        if (ins[14]) n.acc = alu_ref(ins[13:11], s.acc, s.rf[ins[10:9]], ins[7:0]);
        if (ins[15]) n.rf[ins[10:9]] = s.acc;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_dut(input string tag, input logic [15:0] iw, input logic we,
                           input logic re, input logic [2:0] op, input logic [1:0] ad,
                           input mstate_t act, input mstate_t e);
        check({tag, "_noX"}, 32'($isunknown({iw, we, re, op, ad})), 32'd0);
        check({tag, "_ir"}, 32'(iw), 32'(e.ir));
        check({tag, "_decode"}, 32'({we, re, op, ad}), 32'({e.ir[15], e.ir[14], e.ir[13:11], e.ir[10:9]}));
        check({tag, "_pc"}, 32'(act.pc), 32'(e.pc));
        check({tag, "_acc"}, 32'(act.acc), 32'(e.acc));
        check({tag, "_rf"}, act.rf, e.rf);
    endtask

    // Monitor: pop one prediction per cycle and compare both DUTs against it.
    always @(negedge clk) begin
        exp_t    e;
        mstate_t a0, a1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a0.pc = dut0.pc_q;  a0.ir = dut0.ir_q;  a0.acc = dut0.acc_q;
            a1.pc = dut1.pc_q;  a1.ir = dut1.ir_q;  a1.acc = dut1.acc_q;
            for (int i = 0; i < 4; i++) begin
                a0.rf[i] = dut0.rf_q[i];
                a1.rf[i] = dut1.rf_q[i];
            end
            cmp_dut("sb0", iw0, we0, re0, op0, ad0, a0, e.s0);
            cmp_dut("sb1", iw1, we1, re1, op1, ad1, a1, e.s1);
        end
    end

    // One cycle: model the edge, then set rst for the next edge and queue the prediction.
    task automatic tick(input logic r);
        @(posedge clk);
        if (!rst) begin
            m0 = step(m0, DEFAULT_ROM);
            m1 = step(m1, ALT_ROM);
            edges++;
        end
        #2;
        if (r && !rst) begin
            check("pre_rst_pc", 32'(dut0.pc_q), 32'(m0.pc));
            rst = 1'b1;
            #1;
            check("async_rst_outs", 32'({iw0, we0, re0, op0, ad0}), 32'd0);
            check("async_rst_pc", 32'(dut0.pc_q), 32'd0);
            check("async_rst_acc", 32'(dut0.acc_q), 32'd0);
        end else begin
            rst = r;
        end
        if (r) begin
            m0    = '0;
            m1    = '0;
            edges = 0;
        end
        q.push_back({m0, m1});
    endtask

    logic [15:0] fetch_exp [5] = '{16'h4805, 16'h8000, 16'h4803, 16'h5000, 16'h8200};
    int          alt_edge  [7] = '{5, 7, 9, 11, 13, 15, 19};
    logic [7:0]  alt_acc   [7] = '{8'hFF, 8'hE1, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h00};

    initial begin
        m0 = '0;
        m1 = '0;
        repeat (3) tick(1'b1);
        check("reset_outs", 32'({iw0, we0, re0, op0, ad0}), 32'd0);
        check("reset_acc_pc", 32'({dut0.acc_q, dut0.pc_q}), 32'd0);
        tick(1'b0);

        for (int c = 0; c < 80; c++) begin
            tick(1'b0);
            if (edges >= 1 && edges <= 5) check($sformatf("fetch_e%0d", edges), 32'(iw0), 32'(fetch_exp[edges-1]));
            if (edges == 5) check("decode_8200", 32'({we0, ad0}), 32'({1'b1, 2'd1}));
            if (edges == 6) begin
                check("exec_acc", 32'(dut0.acc_q), 32'h08);
                check("exec_r0", 32'(dut0.rf_q[0]), 32'h05);
                check("exec_r1", 32'(dut0.rf_q[1]), 32'h08);
            end
            // One full ROM lap after the first fetch brings word 0 back.
            if (edges == 33) check("wrap_ir", 32'(iw0), 32'h4805);
            for (int k = 0; k < 7; k++)
                if (edges == alt_edge[k]) check($sformatf("alu_sweep_e%0d", edges), 32'(dut1.acc_q), 32'(alt_acc[k]));
        end

        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("restart_fetch", 32'(iw0), 32'h4805);

        for (int c = 0; c < 300; c++) begin
            if (rst) tick($urandom_range(0, 1) == 0);
            else     tick($urandom_range(0, 19) == 0);
        end
        tick(1'b0);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
